tx_gearbox_66to32: RTL and testbench
====================================

# tx_gearbox_66to32

Transmit-side 66-to-32 gearbox for the RD53B Aurora 64b/66b link. It is the counterpart of the receive gearbox and header-sync path. It accepts 66-bit blocks (2-bit sync header plus 64-bit scrambled payload) through a valid/ready handshake. It serialises them MSB-first into a continuous stream of 32-bit words for the serializer. The block sits between the TX scrambler and the serializer and runs on the word clock.

## Interface
- `WORD_W`, 32: output word width; fixed, other values unsupported.
- `BLOCK_W`, 66: input block width; fixed.
- `clk_i` in 1: word clock.
- `rst_i` in 1: reset; asynchronous assert, active-high.
- `block_i` in 66: bits [65:64] are the sync header, bits [63:0] are the payload; bit 65 is transmitted first.
- `block_valid_i` in 1: `block_i` is valid.
- `block_ready_o` out 1: gearbox can take a block this cycle.
- `word_o` out 32: output word; bit 31 is transmitted first.
- `word_valid_o` out 1: `word_o` is new this cycle.
- `underrun_o` out 1: one-cycle pulse when a word slot is missed after streaming has started.
- `fill_o` out 7: current fill level in bits (debug).

## Operation
- Holding register `buf[97:0]` is left-aligned. Valid bits are `buf[97 -: fill]`, and `fill` ranges 0..97.
- `block_ready_o = (fill < 64)`. This is combinational from the `fill` register only, never from `block_valid_i`.
- Accept happens when `block_valid_i && block_ready_o` at a rising edge.
- Emit happens when `fill >= 32` at the edge:
  - `word_o <= buf[97:66]`, `word_valid_o <= 1`.
  - Buffer shifts left by 32 with zero fill.
- Per edge, `fill_next = fill - (emit ? 32 : 0) + (accept ? 66 : 0)`.
  - The accepted block is written at `buf[97 - (fill - emit*32) -: 66]` after the shift.
  - Width rule: intermediate arithmetic is 8 bits; `fill_next` is always ≤ 97.
- No emit (`fill < 32`):
  - `word_valid_o <= 0`, and `word_o` holds its last value.
  - If `started` is set, `underrun_o <= 1`.
  - `started` is set by the first emit after reset.
- Emit and accept on the same edge is legal and is the normal steady-state case.
- The gearbox never drops, reorders or truncates accepted bits. Bit order on the line equals concatenation order of accepted blocks.
- The block applies no scrambling and inserts no idles; the upstream source is responsible for keeping `block_valid_i` high.

## Timing
- Reset values: `buf = 0`, `fill = 0`, `started = 0`, `word_o = 0`, `word_valid_o = 0`, `underrun_o = 0`, `block_ready_o = 1`, `fill_o = 0`.
- Latency: a block accepted at edge N, with `fill = 0` beforehand, gives its first word at `word_o` after edge N+1. Its second word follows after edge N+2.
- Steady state with `block_valid_i` held high:
  - `word_valid_o` is continuously 1 from the second edge after reset release.
  - `block_ready_o` is high in exactly 16 of every 33 cycles, with period 33.
- Ready may drop with a valid block pending; the source must hold `block_i` stable until accepted.
- Reset asserted mid-stream clears all state immediately. Partially emitted blocks are discarded, and no `underrun_o` pulse is generated on recovery.
- `underrun_o` is registered. It pulses for one cycle per missed slot and repeats every cycle while starved.

## Structure
- Shared package `aurora_pkg` holds:
  - `BLOCK_W = 66`, `WORD_W = 32`.
  - Sync header constants `HDR_DATA = 2'b01` and `HDR_CTRL = 2'b10`.
  - Typedef `block_t` (`logic [65:0]`).
- One sub-module, `tx_gbox_shifter`, is combinational. It computes the next `buf` and `fill` from the current `buf`, `fill`, emit, accept and `block_i`. The top module holds the registers, handshake and underrun logic.

## Test plan
- Reset release, then block `{2'b10, 64'h0123456789ABCDEF}` with `valid = 1` -> after the next edge, `word_o = 32'h8048D159` and `word_valid_o = 1`.
- 64 random blocks streamed back-to-back -> the concatenated `word_o` stream matches the concatenated blocks bit-exact. `word_valid_o` never drops after the first word, and `underrun_o` is never 1.
- Continuous valid for 330 cycles -> `block_ready_o` high exactly 160 times, with a period-33 pattern once steady.
- Withhold valid for 5 cycles mid-stream -> `word_valid_o` drops once `fill < 32`, with a one-cycle `underrun_o` pulse per missed slot. The stream resumes bit-exact, with no lost or duplicated bits.
- Assert `rst_i` asynchronously with `fill = 66` -> all outputs return to their reset values before the next edge. The next block after release again yields its `[65:34]` word first.
- Hold `block_valid_i` high while `fill >= 64` -> `block_i` is not consumed, and `fill_o` decreases by 32 on that edge.

Source files
------------

// File: rtl/aurora_pkg.sv
// Shared constants and types for the RD53B Aurora 64b/66b transmit path.
package aurora_pkg;

  localparam int unsigned BLOCK_W = 66;
  localparam int unsigned WORD_W  = 32;
  // Holding register: up to 31 leftover bits plus one full block.
  localparam int unsigned BUF_W   = 98;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  typedef logic [BLOCK_W-1:0] block_t;

endpackage

// File: rtl/tx_gbox_shifter.sv
// Next-state datapath of the 66-to-32 gearbox: drops an emitted word from
// the top of the left-aligned holding register and appends an accepted block
// directly behind the bits that remain.
module tx_gbox_shifter
  import aurora_pkg::*;
(
  input  logic [BUF_W-1:0] buf_i,
  input  logic [6:0]       fill_i,
  input  logic             emit_i,
  input  logic             accept_i,
  input  block_t           block_i,
  output logic [BUF_W-1:0] buf_o,
  output logic [6:0]       fill_o
);

  logic [7:0]       w_base;
  logic [BUF_W-1:0] w_shifted;
  logic [BUF_W-1:0] w_insert;

  // Shift out the emitted word, then place the new block at the post-shift fill point.
  always_comb begin
    w_base    = {1'b0, fill_i} - (emit_i ? 8'd32 : 8'd0);
    w_shifted = emit_i ? (buf_i << WORD_W) : buf_i;
    w_insert  = '0;
    // Accept implies w_base < 32, so the block always fits below bit 97.
    if (accept_i) begin
      w_insert = {block_i, {(BUF_W-BLOCK_W){1'b0}}} >> w_base;
    end
    buf_o  = w_shifted | w_insert;
    fill_o = 7'(w_base + (accept_i ? 8'd66 : 8'd0));
  end

endmodule

// File: rtl/tx_gearbox_66to32.sv
// Transmit gearbox: 66-bit blocks in via valid/ready, 32-bit words out
// MSB-first on every word clock once enough bits are buffered.
module tx_gearbox_66to32
  import aurora_pkg::BUF_W;
#(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned BLOCK_W = 66
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [BLOCK_W-1:0] block_i,
  input  logic               block_valid_i,
  output logic               block_ready_o,
  output logic [WORD_W-1:0]  word_o,
  output logic               word_valid_o,
  output logic               underrun_o,
  output logic [6:0]         fill_o
);

  logic [BUF_W-1:0]  r_hold;
  logic [6:0]        r_fill;
  logic              r_started;
  logic [WORD_W-1:0] r_word;
  logic              r_word_valid;
  logic              r_underrun;

  logic [BUF_W-1:0]  w_hold_next;
  logic [6:0]        w_fill_next;
  logic              w_emit;
  logic              w_accept;
  logic              w_ready;

  // Handshake and emit decisions depend only on the registered fill level.
  always_comb begin
    w_ready  = (r_fill < 7'd64);
    w_emit   = (r_fill >= 7'd32);
    w_accept = block_valid_i && w_ready;
  end

  tx_gbox_shifter u_shifter (
    .buf_i    (r_hold),
    .fill_i   (r_fill),
    .emit_i   (w_emit),
    .accept_i (w_accept),
    .block_i  (block_i),
    .buf_o    (w_hold_next),
    .fill_o   (w_fill_next)
  );

  // Holding register, fill level, output word and underrun tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold       <= '0;
      r_fill       <= '0;
      r_started    <= 1'b0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_hold       <= w_hold_next;
      r_fill       <= w_fill_next;
      r_word_valid <= w_emit;
      r_underrun   <= !w_emit && r_started;
      if (w_emit) begin
        r_word    <= r_hold[BUF_W-1 -: WORD_W];
        r_started <= 1'b1;
      end
    end
  end

  assign block_ready_o = w_ready;
  assign word_o        = r_word;
  assign word_valid_o  = r_word_valid;
  assign underrun_o    = r_underrun;
  assign fill_o        = r_fill;

endmodule

// File: tb/tb_tx_gearbox_66to32.sv
// Self-checking bench for tx_gearbox_66to32 using a bit-queue reference model.
module tb_tx_gearbox_66to32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [65:0] blk = '0;
  logic        vld = 1'b0;
  logic        ready;
  logic [31:0] word;
  logic        wv;
  logic        und;
  logic [6:0]  fill;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the line is simply a FIFO of bits.
  bit          mq[$];
  bit          m_started;
  logic [31:0] m_word;
  logic        m_wv;
  logic        m_und;

  always #5 clk = ~clk;

  tx_gearbox_66to32 #(.WORD_W(32), .BLOCK_W(66)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .block_i       (blk),
    .block_valid_i (vld),
    .block_ready_o (ready),
    .word_o        (word),
    .word_valid_o  (wv),
    .underrun_o    (und),
    .fill_o        (fill)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mq.delete();
    m_started = 1'b0;
    m_word    = '0;
    m_wv      = 1'b0;
    m_und     = 1'b0;
  endtask

  function automatic logic [41:0] exp_vec();
    return {m_wv, m_und, 7'(mq.size()), (mq.size() < 64), m_word};
  endfunction

  function automatic logic [41:0] obs_vec();
    return {wv, und, fill, ready, word};
  endfunction

  // Drive one cycle of input, pass the edge, then advance the model.
  task automatic step(input logic v, input logic [65:0] b, output bit acc);
    bit emit;
    vld  = v;
    blk  = b;
    acc  = v && (mq.size() < 64);
    emit = (mq.size() >= 32);
    @(posedge clk);
    #1;
    if (emit) for (int i = 0; i < 32; i++) m_word[31-i] = mq.pop_front();
    m_wv  = emit;
    m_und = !emit && m_started;
    if (emit) m_started = 1'b1;
    if (acc) for (int i = 65; i >= 0; i--) mq.push_back(b[i]);
  endtask

  task automatic apply_reset();
    vld = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [65:0] rand_blk();
    logic [65:0] b;
    b = {($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, $urandom(), $urandom()};
    return b;
  endfunction

  task automatic test_reset();
    #1;
    n_chk++;
    if (obs_vec() !== {1'b0, 1'b0, 7'd0, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), {1'b0, 1'b0, 7'd0, 1'b1, 32'h0});
    end
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_first_word();
    bit acc;
    logic [65:0] b;
    b = {2'b10, 64'h0123456789ABCDEF};
    step(1'b1, b, acc);
    n_chk++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL first_accept got=%h exp=%h", obs_vec(), exp_vec());
    end
    step(1'b0, '0, acc);
    n_chk++;
    if (word !== 32'h8048D159 || wv !== 1'b1) begin
      n_err++;
      $display("FAIL first_word got=%h/%b exp=8048d159/1", word, wv);
    end
    step(1'b0, '0, acc);
    n_chk++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL second_word got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [65:0] blocks[64];
    bit rq[$];
    bit dq[$];
    bit acc, seen, dropped, any_und;
    int j, cyc, bad;
    apply_reset();
    for (int k = 0; k < 64; k++) begin
      blocks[k] = rand_blk();
      for (int i = 65; i >= 0; i--) rq.push_back(blocks[k][i]);
    end
    j = 0; cyc = 0; seen = 0; dropped = 0; any_und = 0;
    while (j < 64 && cyc < 400) begin
      step(1'b1, blocks[j], acc);
      if (acc) j++;
      cyc++;
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL b2b_cycle[%0d] got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (seen && !wv) dropped = 1;
      if (und) any_und = 1;
      if (wv) begin
        seen = 1;
        for (int i = 31; i >= 0; i--) dq.push_back(word[i]);
      end
    end
    n_chk++;
    if (j != 64) begin
      n_err++;
      $display("FAIL b2b_accept_count got=%0d exp=64", j);
    end
    bad = 0;
    for (int i = 0; i < dq.size(); i++) if (dq[i] != rq[i]) bad++;
    n_chk++;
    if (bad != 0 || dq.size() < 64*66 - 97) begin
      n_err++;
      $display("FAIL b2b_stream bad_bits=%0d got_bits=%0d exp_min_bits=%0d", bad, dq.size(), 64*66-97);
    end
    n_chk++;
    if (dropped || any_und) begin
      n_err++;
      $display("FAIL b2b_continuity dropped=%0b underrun=%0b exp=0/0", dropped, any_und);
    end
  endtask

  task automatic test_ready_period();
    bit r[330];
    bit acc;
    int cnt, bad;
    logic [65:0] b;
    apply_reset();
    b = rand_blk();
    cnt = 0;
    for (int k = 0; k < 330; k++) begin
      r[k] = ready;
      if (ready) cnt++;
      step(1'b1, b, acc);
      if (acc) b = rand_blk();
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL ready_cycle[%0d] got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (cnt != 160) begin
      n_err++;
      $display("FAIL ready_count got=%0d exp=160", cnt);
    end
    bad = 0;
    for (int k = 66; k < 330; k++) if (r[k] != r[k-33]) bad++;
    n_chk++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL ready_period33 deviations=%0d exp=0", bad);
    end
  endtask

  task automatic test_underrun();
    bit acc;
    int du, mu;
    logic [65:0] b;
    b = rand_blk();
    du = 0; mu = 0;
    for (int k = 0; k < 25; k++) begin
      step((k < 5) ? 1'b0 : 1'b1, b, acc);
      if (acc) b = rand_blk();
      if (und) du++;
      if (m_und) mu++;
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL starve_cycle[%0d] got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (du != mu || mu == 0) begin
      n_err++;
      $display("FAIL underrun_pulses got=%0d exp=%0d (exp nonzero)", du, mu);
    end
  endtask

  task automatic test_async_reset();
    bit acc;
    int cyc;
    logic [65:0] b;
    b = rand_blk();
    cyc = 0;
    while (!(mq.size() == 66 && m_wv) && cyc < 100) begin
      step(1'b1, b, acc);
      if (acc) b = rand_blk();
      cyc++;
    end
    n_chk++;
    if (fill !== 7'd66 || wv !== 1'b1) begin
      n_err++;
      $display("FAIL reach_fill66 got=%0d/%b exp=66/1", fill, wv);
    end
    #3;
    rst = 1'b1;
    #1;
    n_chk++;
    if (obs_vec() !== {1'b0, 1'b0, 7'd0, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL async_reset got=%h exp=%h", obs_vec(), {1'b0, 1'b0, 7'd0, 1'b1, 32'h0});
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    b = rand_blk();
    step(1'b1, b, acc);
    step(1'b0, '0, acc);
    n_chk++;
    if (word !== b[65:34] || wv !== 1'b1 || und !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_word got=%h/%b/%b exp=%h/1/0", word, wv, und, b[65:34]);
    end
    step(1'b0, '0, acc);
    n_chk++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL post_reset_drain got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_full_hold();
    bit acc;
    logic [65:0] b1, b2;
    int pre;
    apply_reset();
    b1 = rand_blk();
    b2 = rand_blk();
    step(1'b1, b1, acc);
    n_chk++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready got=%b exp=0", ready);
    end
    pre = mq.size();
    step(1'b1, b2, acc);
    n_chk++;
    if (acc || fill !== 7'(pre - 32) || word !== b1[65:34]) begin
      n_err++;
      $display("FAIL full_hold fill=%0d exp=%0d word=%h exp=%h", fill, pre - 32, word, b1[65:34]);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, b2, acc);
      if (acc) b2 = rand_blk();
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL full_follow[%0d] got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_word();
    test_back_to_back();
    test_ready_period();
    test_underrun();
    test_async_reset();
    test_full_hold();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
